// File: rtl/cluster_pwr_seq_if.sv
// Control bundle between the FC-side power registers and the cluster power sequencer.
// master = FC side (drives requests), slave = sequencer (drives cluster controls).
interface cluster_pwr_seq_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  pwr_req_i;
  logic [ADDR_WIDTH-1:0] boot_addr_i;
  logic                  fetch_en_i;
  logic                  cluster_busy_i;
  logic                  cluster_pow_o;
  logic                  cluster_clk_en_o;
  logic                  cluster_rstn_o;
  logic                  cluster_fetch_enable_o;
  logic [ADDR_WIDTH-1:0] cluster_boot_addr_o;
  logic                  pwr_ack_o;
  logic                  evt_o;
  logic [2:0]            state_o;
  logic                  timeout_o;

  modport master (
    output pwr_req_i, boot_addr_i, fetch_en_i, cluster_busy_i,
    input  cluster_pow_o, cluster_clk_en_o, cluster_rstn_o, cluster_fetch_enable_o,
           cluster_boot_addr_o, pwr_ack_o, evt_o, state_o, timeout_o
  );

  modport slave (
    input  pwr_req_i, boot_addr_i, fetch_en_i, cluster_busy_i,
    output cluster_pow_o, cluster_clk_en_o, cluster_rstn_o, cluster_fetch_enable_o,
           cluster_boot_addr_o, pwr_ack_o, evt_o, state_o, timeout_o
  );
endinterface

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: supply -> clock -> reset release -> run, and drain -> clock/supply off.
// Optional forced power-down on a stuck busy cluster: define CLUSTER_PWR_SEQ_DRAIN_TIMEOUT_EN.
module cluster_pwr_seq #(
  parameter int PWR_UP_CYCLES = 16,
  parameter int RST_CYCLES    = 8,
  parameter int ADDR_WIDTH    = 64,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               dft_test_mode_i,
  cluster_pwr_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWR_UP  = 3'd1,
    S_CLK_ON  = 3'd2,
    S_RST_REL = 3'd3,
    S_RUN     = 3'd4,
    S_DRAIN   = 3'd5,
    S_CLK_OFF = 3'd6
  } state_e;

  localparam logic [CNT_WIDTH-1:0] PWR_UP_LOAD = CNT_WIDTH'(PWR_UP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RST_LOAD    = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD  = CNT_WIDTH'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pow_q, pow_d;
  logic                  clk_en_q, clk_en_d;
  logic                  rstn_q, rstn_d;
  logic                  fetch_q, fetch_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ack_q, ack_d;
  logic                  evt_q, evt_d;
  logic                  tmo_q, tmo_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pow_d    = pow_q;
    clk_en_d = clk_en_q;
    rstn_d   = rstn_q;
    fetch_d  = fetch_q;
    addr_d   = addr_q;
    evt_d    = 1'b0;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_OFF: begin
        pow_d    = 1'b0;
        clk_en_d = 1'b0;
        rstn_d   = 1'b0;
        fetch_d  = 1'b0;
        if (bus.pwr_req_i) begin
          state_d = S_PWR_UP;
          addr_d  = bus.boot_addr_i;
          cnt_d   = PWR_UP_LOAD;
          pow_d   = 1'b1;
          tmo_d   = 1'b0;
        end
      end
      S_PWR_UP: begin
        if (cnt_q == '0) begin
          state_d  = S_CLK_ON;
          clk_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_CLK_ON: begin
        state_d = S_RST_REL;
        cnt_d   = RST_LOAD;
      end
      S_RST_REL: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          rstn_d  = 1'b1;
          evt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RUN: begin
        if (!bus.pwr_req_i) begin
          state_d = S_DRAIN;
          fetch_d = 1'b0;
          cnt_d   = DRAIN_LOAD;
        end else begin
          fetch_d = bus.fetch_en_i;
        end
      end
      S_DRAIN: begin
        // A renewed request beats a simultaneous busy drop: the cluster is still live.
        fetch_d = 1'b0;
        if (bus.pwr_req_i) begin
          state_d = S_RUN;
        end else if (!bus.cluster_busy_i) begin
          state_d  = S_CLK_OFF;
          clk_en_d = 1'b0;
          rstn_d   = 1'b0;
        end
`ifdef CLUSTER_PWR_SEQ_DRAIN_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d  = S_CLK_OFF;
          clk_en_d = 1'b0;
          rstn_d   = 1'b0;
          tmo_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
      end
      S_CLK_OFF: begin
        state_d = S_OFF;
        pow_d   = 1'b0;
        evt_d   = 1'b1;
      end
      default: begin
        state_d  = S_OFF;
        pow_d    = 1'b0;
        clk_en_d = 1'b0;
        rstn_d   = 1'b0;
        fetch_d  = 1'b0;
      end
    endcase
    ack_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      pow_q    <= 1'b0;
      clk_en_q <= 1'b0;
      rstn_q   <= 1'b0;
      fetch_q  <= 1'b0;
      addr_q   <= '0;
      ack_q    <= 1'b0;
      evt_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pow_q    <= pow_d;
      clk_en_q <= clk_en_d;
      rstn_q   <= rstn_d;
      fetch_q  <= fetch_d;
      addr_q   <= addr_d;
      ack_q    <= ack_d;
      evt_q    <= evt_d;
      tmo_q    <= tmo_d;
    end
  end

  // Test mode hands cluster reset straight to the SoC reset pin for scan control.
  assign bus.cluster_rstn_o         = dft_test_mode_i ? rst_ni : rstn_q;
  assign bus.cluster_pow_o          = pow_q;
  assign bus.cluster_clk_en_o       = clk_en_q;
  assign bus.cluster_fetch_enable_o = fetch_q;
  assign bus.cluster_boot_addr_o    = addr_q;
  assign bus.pwr_ack_o              = ack_q;
  assign bus.evt_o                  = evt_q;
  assign bus.state_o                = state_q;
  assign bus.timeout_o              = tmo_q;

endmodule
